alu_seq_param: RTL



---
 rtl/alu_seq_param.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// Registered parametrised ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops; MUL runs as a WIDTH-cycle radix-2 shift-add loop.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   y_hi_q, y_hi_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   sub_diff;
    logic [WIDTH:0]     mul_sum;

    // Datapath shared by the accept decode and the multiply loop
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        sub_diff = a - b;
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]}
                 + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_hi_d      = y_hi_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                    end else begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        y_d         = '0;
                        y_hi_d      = '0;
                        carry_d     = 1'b0;
                        overflow_d  = 1'b0;
                        err_d       = 1'b0;
                        case (opcode)
                            OP_ADD: begin
                                y_d        = add_sum[WIDTH-1:0];
                                carry_d    = add_sum[WIDTH];
                                overflow_d = (a[WIDTH-1] == b[WIDTH-1])
                                          && (add_sum[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_SUB: begin
                                y_d        = sub_diff;
                                carry_d    = (a < b);
                                overflow_d = (a[WIDTH-1] != b[WIDTH-1])
                                          && (sub_diff[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_AND:  y_d = a & b;
                            OP_OR:   y_d = a | b;
                            OP_XOR:  y_d = a ^ b;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end

            ST_MUL: begin
                // Conditional add into the upper half, then shift the whole accumulator right
                acc_d    = ACC_W'({mul_sum, acc_q[WIDTH-1:0]} >> 1);
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    y_d         = acc_d[WIDTH-1:0];
                    y_hi_d      = acc_d[ACC_W-1:WIDTH];
                    carry_d     = 1'b0;
                    overflow_d  = 1'b0;
                    err_d       = 1'b0;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_hi_q      <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_hi_q      <= y_hi_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule
